// File: rtl/reorder_buffer_pkg.sv
// Shared constants and types for the reorder buffer: default geometry,
// completion-port priority ranking and the hard-wired zero register.
package reorder_buffer_pkg;

   localparam int unsigned ROB_DEPTH = 8;
   localparam int unsigned ROB_TAG_W = 3;

   // Lower value wins when two units report the same tag in one cycle.
   typedef enum logic [1:0] {
      UnitMem = 2'd0,
      UnitAm  = 2'd1,
      UnitMul = 2'd2
   } unit_e;

   localparam int unsigned NUM_UNITS = 3;

   localparam logic [4:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/rob_pending_match.sv
// Combinational RAW-hazard query: is any live entry still going to write qaddr?
module rob_pending_match
   import reorder_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = ROB_DEPTH
) (
   input  logic [DEPTH-1:0] i_valid,
   input  logic [DEPTH-1:0] i_wreg,
   input  logic [4:0]       i_dest [DEPTH],
   input  logic [4:0]       i_qaddr,
   output logic             o_busy
);

   always_comb begin
      o_busy = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (i_valid[i] && i_wreg[i] && (i_dest[i] == i_qaddr)) begin
            o_busy = 1'b1;
         end
      end
      // r0 is never written, so it can never be a hazard.
      if (i_qaddr == ZERO_REG) begin
         o_busy = 1'b0;
      end
   end

endmodule

// File: rtl/reorder_buffer.sv
// In-order commit buffer: tags allocated at tail, completions land out of
// order, head retires one register write per cycle.
module reorder_buffer
   import reorder_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = ROB_DEPTH,
   parameter int unsigned TAG_W = ROB_TAG_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             iss_rob_alloc,
   input  logic [4:0]       iss_rob_regdest,
   input  logic             iss_rob_writereg,
   output logic [TAG_W-1:0] rob_iss_tag,
   output logic             rob_iss_full,
   output logic             rob_iss_empty,
   input  logic [4:0]       iss_rob_qaddr,
   output logic             rob_iss_qbusy,
   input  logic             mul_rob_oper,
   input  logic [TAG_W-1:0] mul_rob_tag,
   input  logic [31:0]      mul_rob_wbvalue,
   input  logic             am_rob_oper,
   input  logic [TAG_W-1:0] am_rob_tag,
   input  logic [31:0]      am_rob_wbvalue,
   input  logic             mem_rob_oper,
   input  logic [TAG_W-1:0] mem_rob_tag,
   input  logic [31:0]      mem_rob_wbvalue,
   output logic             rob_reg_en,
   output logic [4:0]       rob_reg_addr,
   output logic [31:0]      rob_reg_data
);

   localparam logic [TAG_W:0] CountFull = (TAG_W+1)'(DEPTH);

   logic [DEPTH-1:0] r_valid;
   logic [DEPTH-1:0] r_done;
   logic [DEPTH-1:0] r_wreg;
   logic [4:0]       r_dest  [DEPTH];
   logic [31:0]      r_value [DEPTH];
   logic [TAG_W-1:0] r_head;
   logic [TAG_W-1:0] r_tail;
   logic [TAG_W:0]   r_count;

   logic             w_full;
   logic             w_empty;
   logic             w_accept;
   logic             w_commit;
   logic             w_oper [NUM_UNITS];
   logic [TAG_W-1:0] w_tag  [NUM_UNITS];
   logic [31:0]      w_val  [NUM_UNITS];

   assign w_full   = (r_count == CountFull);
   assign w_empty  = (r_count == '0);
   assign w_accept = iss_rob_alloc && !w_full;
   // Uses pre-edge done, so a same-edge completion of head cannot commit early.
   assign w_commit = r_valid[r_head] && r_done[r_head];

   assign rob_iss_tag   = r_tail;
   assign rob_iss_full  = w_full;
   assign rob_iss_empty = w_empty;

   always_comb begin
      w_oper[UnitMem] = mem_rob_oper;
      w_tag[UnitMem]  = mem_rob_tag;
      w_val[UnitMem]  = mem_rob_wbvalue;
      w_oper[UnitAm]  = am_rob_oper;
      w_tag[UnitAm]   = am_rob_tag;
      w_val[UnitAm]   = am_rob_wbvalue;
      w_oper[UnitMul] = mul_rob_oper;
      w_tag[UnitMul]  = mul_rob_tag;
      w_val[UnitMul]  = mul_rob_wbvalue;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_valid      <= '0;
         r_done       <= '0;
         r_head       <= '0;
         r_tail       <= '0;
         r_count      <= '0;
         rob_reg_en   <= 1'b0;
         rob_reg_addr <= '0;
         rob_reg_data <= '0;
      end else begin
         rob_reg_en <= 1'b0;
         if (w_commit) begin
            rob_reg_en      <= r_wreg[r_head] && (r_dest[r_head] != ZERO_REG);
            rob_reg_addr    <= r_dest[r_head];
            rob_reg_data    <= r_value[r_head];
            r_valid[r_head] <= 1'b0;
            r_head          <= r_head + TAG_W'(1);
         end
         // Lowest-priority unit first so a higher-priority write lands last.
         for (int u = NUM_UNITS - 1; u >= 0; u--) begin
            if (w_oper[u] && r_valid[w_tag[u]]) begin
               r_done[w_tag[u]]  <= 1'b1;
               r_value[w_tag[u]] <= w_val[u];
            end
         end
         if (w_accept) begin
            r_valid[r_tail] <= 1'b1;
            r_done[r_tail]  <= 1'b0;
            r_wreg[r_tail]  <= iss_rob_writereg;
            r_dest[r_tail]  <= iss_rob_regdest;
            r_tail          <= r_tail + TAG_W'(1);
         end
         r_count <= r_count + (TAG_W+1)'(w_accept) - (TAG_W+1)'(w_commit);
      end
   end

   rob_pending_match #(
      .DEPTH (DEPTH)
   ) u_pending_match (
      .i_valid (r_valid),
      .i_wreg  (r_wreg),
      .i_dest  (r_dest),
      .i_qaddr (iss_rob_qaddr),
      .o_busy  (rob_iss_qbusy)
   );

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: expected commits queued at allocation,
// popped by a negedge monitor; scenario tasks check flags and commit timing.
module tb_reorder_buffer;

   localparam int TAG_W = 3;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             iss_rob_alloc = 1'b0;
   logic [4:0]       iss_rob_regdest = '0;
   logic             iss_rob_writereg = 1'b0;
   logic [TAG_W-1:0] rob_iss_tag;
   logic             rob_iss_full;
   logic             rob_iss_empty;
   logic [4:0]       iss_rob_qaddr = '0;
   logic             rob_iss_qbusy;
   logic             mul_rob_oper = 1'b0;
   logic [TAG_W-1:0] mul_rob_tag = '0;
   logic [31:0]      mul_rob_wbvalue = '0;
   logic             am_rob_oper = 1'b0;
   logic [TAG_W-1:0] am_rob_tag = '0;
   logic [31:0]      am_rob_wbvalue = '0;
   logic             mem_rob_oper = 1'b0;
   logic [TAG_W-1:0] mem_rob_tag = '0;
   logic [31:0]      mem_rob_wbvalue = '0;
   logic             rob_reg_en;
   logic [4:0]       rob_reg_addr;
   logic [31:0]      rob_reg_data;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   commit_cyc_q[$];
   exp_t mon_e;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   reorder_buffer #(
      .DEPTH (8),
      .TAG_W (TAG_W)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .iss_rob_alloc    (iss_rob_alloc),
      .iss_rob_regdest  (iss_rob_regdest),
      .iss_rob_writereg (iss_rob_writereg),
      .rob_iss_tag      (rob_iss_tag),
      .rob_iss_full     (rob_iss_full),
      .rob_iss_empty    (rob_iss_empty),
      .iss_rob_qaddr    (iss_rob_qaddr),
      .rob_iss_qbusy    (rob_iss_qbusy),
      .mul_rob_oper     (mul_rob_oper),
      .mul_rob_tag      (mul_rob_tag),
      .mul_rob_wbvalue  (mul_rob_wbvalue),
      .am_rob_oper      (am_rob_oper),
      .am_rob_tag       (am_rob_tag),
      .am_rob_wbvalue   (am_rob_wbvalue),
      .mem_rob_oper     (mem_rob_oper),
      .mem_rob_tag      (mem_rob_tag),
      .mem_rob_wbvalue  (mem_rob_wbvalue),
      .rob_reg_en       (rob_reg_en),
      .rob_reg_addr     (rob_reg_addr),
      .rob_reg_data     (rob_reg_data)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Every register write must match the oldest outstanding expectation.
   always @(negedge clock) begin
      if (rob_reg_en === 1'b1) begin
         checks++;
         commit_cyc_q.push_back(cyc);
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL commit_unexpected got addr=%0d data=%h required no write",
                     rob_reg_addr, rob_reg_data);
         end else begin
            mon_e = exp_q.pop_front();
            if (rob_reg_addr !== mon_e.addr || rob_reg_data !== mon_e.data) begin
               errors++;
               $display("FAIL commit_value got addr=%0d data=%h required addr=%0d data=%h",
                        rob_reg_addr, rob_reg_data, mon_e.addr, mon_e.data);
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      exp_q.delete();
      commit_cyc_q.delete();
   endtask

   task automatic alloc(input logic [4:0] dest, input logic wreg);
      iss_rob_alloc    = 1'b1;
      iss_rob_regdest  = dest;
      iss_rob_writereg = wreg;
      idle(1);
      iss_rob_alloc    = 1'b0;
   endtask

   task automatic expect_write(input logic [4:0] addr, input logic [31:0] data);
      exp_t e;
      e.addr = addr;
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (rob_iss_empty !== 1'b1) begin
         errors++; $display("FAIL reset_empty got %b required 1", rob_iss_empty);
      end
      checks++;
      if (rob_iss_full !== 1'b0) begin
         errors++; $display("FAIL reset_full got %b required 0", rob_iss_full);
      end
      checks++;
      if (rob_reg_en !== 1'b0 || rob_reg_addr !== 5'd0 || rob_reg_data !== 32'd0) begin
         errors++;
         $display("FAIL reset_regport got en=%b addr=%0d data=%h required 0/0/0",
                  rob_reg_en, rob_reg_addr, rob_reg_data);
      end
      checks++;
      if (rob_iss_tag !== 3'd0) begin
         errors++; $display("FAIL reset_tag got %0d required 0", rob_iss_tag);
      end
   endtask

   task automatic test_out_of_order();
      int k;
      do_reset();
      alloc(5'd3, 1'b1); expect_write(5'd3, 32'h0000_00AA);
      alloc(5'd4, 1'b1); expect_write(5'd4, 32'h0000_0011);
      alloc(5'd5, 1'b1); expect_write(5'd5, 32'h0000_0022);
      checks++;
      if (rob_iss_tag !== 3'd3) begin
         errors++; $display("FAIL ooo_tag got %0d required 3", rob_iss_tag);
      end
      mul_rob_oper = 1'b1; mul_rob_tag = 3'd2; mul_rob_wbvalue = 32'h22;
      idle(1);
      mul_rob_oper = 1'b0;
      am_rob_oper = 1'b1; am_rob_tag = 3'd1; am_rob_wbvalue = 32'h11;
      idle(1);
      am_rob_oper = 1'b0;
      idle(2);
      checks++;
      if (exp_q.size() != 3) begin
         errors++; $display("FAIL ooo_held got %0d pending required 3", exp_q.size());
      end
      mem_rob_oper = 1'b1; mem_rob_tag = 3'd0; mem_rob_wbvalue = 32'hAA;
      k = cyc;
      idle(1);
      mem_rob_oper = 1'b0;
      idle(5);
      checks++;
      if (commit_cyc_q.size() != 3) begin
         errors++; $display("FAIL ooo_count got %0d commits required 3", commit_cyc_q.size());
      end else if (commit_cyc_q[0] != k + 2 || commit_cyc_q[1] != k + 3 ||
                   commit_cyc_q[2] != k + 4) begin
         errors++;
         $display("FAIL ooo_timing got cycles %0d,%0d,%0d required %0d,%0d,%0d",
                  commit_cyc_q[0], commit_cyc_q[1], commit_cyc_q[2], k + 2, k + 3, k + 4);
      end
      checks++;
      if (rob_iss_empty !== 1'b1) begin
         errors++; $display("FAIL ooo_empty got %b required 1", rob_iss_empty);
      end
   endtask

   task automatic test_full_wrap();
      do_reset();
      for (int i = 0; i < 8; i++) alloc(5'(8 + i), 1'b1);
      expect_write(5'd8, 32'h100);
      checks++;
      if (rob_iss_full !== 1'b1 || rob_iss_tag !== 3'd0) begin
         errors++;
         $display("FAIL full_set got full=%b tag=%0d required 1/0", rob_iss_full, rob_iss_tag);
      end
      alloc(5'd20, 1'b1);
      checks++;
      if (rob_iss_full !== 1'b1 || rob_iss_tag !== 3'd0) begin
         errors++;
         $display("FAIL full_ninth got full=%b tag=%0d required 1/0", rob_iss_full, rob_iss_tag);
      end
      mem_rob_oper = 1'b1; mem_rob_tag = 3'd0; mem_rob_wbvalue = 32'h100;
      idle(1);
      mem_rob_oper = 1'b0;
      // Alloc held across the commit edge while still full: must be rejected.
      alloc(5'd21, 1'b1);
      checks++;
      if (rob_iss_full !== 1'b0 || rob_iss_tag !== 3'd0) begin
         errors++;
         $display("FAIL full_commit_alloc got full=%b tag=%0d required 0/0",
                  rob_iss_full, rob_iss_tag);
      end
      alloc(5'd22, 1'b1);
      checks++;
      if (rob_iss_full !== 1'b1 || rob_iss_tag !== 3'd1) begin
         errors++;
         $display("FAIL full_wrap got full=%b tag=%0d required 1/1", rob_iss_full, rob_iss_tag);
      end
      idle(1);
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL full_drain got %0d pending required 0", exp_q.size());
      end
   endtask

   task automatic test_same_cycle();
      int k;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         alloc(5'(10 + i), 1'b1);
         expect_write(5'(10 + i), 32'(32'h30 + i));
      end
      alloc(5'd13, 1'b1); expect_write(5'd13, 32'h33);
      alloc(5'd14, 1'b1); expect_write(5'd14, 32'h44);
      for (int i = 0; i < 3; i++) begin
         mul_rob_oper = 1'b1; mul_rob_tag = 3'(i); mul_rob_wbvalue = 32'(32'h30 + i);
         idle(1);
      end
      mul_rob_oper = 1'b0;
      idle(3);
      checks++;
      if (exp_q.size() != 2) begin
         errors++; $display("FAIL same_head3 got %0d pending required 2", exp_q.size());
      end
      commit_cyc_q.delete();
      am_rob_oper  = 1'b1; am_rob_tag  = 3'd3; am_rob_wbvalue  = 32'h33;
      mem_rob_oper = 1'b1; mem_rob_tag = 3'd4; mem_rob_wbvalue = 32'h44;
      k = cyc;
      idle(1);
      am_rob_oper = 1'b0; mem_rob_oper = 1'b0;
      idle(4);
      checks++;
      if (commit_cyc_q.size() != 2) begin
         errors++; $display("FAIL same_count got %0d commits required 2", commit_cyc_q.size());
      end else if (commit_cyc_q[0] != k + 2 || commit_cyc_q[1] != k + 3) begin
         errors++;
         $display("FAIL same_timing got cycles %0d,%0d required %0d,%0d",
                  commit_cyc_q[0], commit_cyc_q[1], k + 2, k + 3);
      end
   endtask

   task automatic test_qbusy();
      do_reset();
      iss_rob_qaddr = 5'd7;
      #1;
      checks++;
      if (rob_iss_qbusy !== 1'b0) begin
         errors++; $display("FAIL qbusy_idle got %b required 0", rob_iss_qbusy);
      end
      alloc(5'd7, 1'b1); expect_write(5'd7, 32'h77);
      checks++;
      if (rob_iss_qbusy !== 1'b1) begin
         errors++; $display("FAIL qbusy_alloc got %b required 1", rob_iss_qbusy);
      end
      mul_rob_oper = 1'b1; mul_rob_tag = 3'd0; mul_rob_wbvalue = 32'h77;
      idle(1);
      mul_rob_oper = 1'b0;
      checks++;
      if (rob_iss_qbusy !== 1'b1) begin
         errors++; $display("FAIL qbusy_done got %b required 1", rob_iss_qbusy);
      end
      idle(1);
      checks++;
      if (rob_iss_qbusy !== 1'b0) begin
         errors++; $display("FAIL qbusy_commit got %b required 0", rob_iss_qbusy);
      end
      alloc(5'd0, 1'b1);
      iss_rob_qaddr = 5'd0;
      #1;
      checks++;
      if (rob_iss_qbusy !== 1'b0) begin
         errors++; $display("FAIL qbusy_r0 got %b required 0", rob_iss_qbusy);
      end
      am_rob_oper = 1'b1; am_rob_tag = 3'd1; am_rob_wbvalue = 32'h99;
      idle(1);
      am_rob_oper = 1'b0;
      idle(3);
      checks++;
      if (rob_iss_empty !== 1'b1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL qbusy_r0_retire got empty=%b pending=%0d required 1/0",
                  rob_iss_empty, exp_q.size());
      end
   endtask

   task automatic test_store();
      int k;
      do_reset();
      iss_rob_qaddr = 5'd2;
      alloc(5'd2, 1'b0);
      checks++;
      if (rob_iss_qbusy !== 1'b0) begin
         errors++; $display("FAIL store_qbusy got %b required 0", rob_iss_qbusy);
      end
      alloc(5'd2, 1'b1); expect_write(5'd2, 32'hBEEF);
      checks++;
      if (rob_iss_qbusy !== 1'b1) begin
         errors++; $display("FAIL store_r2_qbusy got %b required 1", rob_iss_qbusy);
      end
      mul_rob_oper = 1'b1; mul_rob_tag = 3'd0; mul_rob_wbvalue = 32'h5555;
      am_rob_oper  = 1'b1; am_rob_tag  = 3'd1; am_rob_wbvalue  = 32'hBEEF;
      k = cyc;
      idle(1);
      mul_rob_oper = 1'b0; am_rob_oper = 1'b0;
      idle(4);
      checks++;
      if (commit_cyc_q.size() != 1) begin
         errors++; $display("FAIL store_count got %0d writes required 1", commit_cyc_q.size());
      end else if (commit_cyc_q[0] != k + 3) begin
         errors++;
         $display("FAIL store_timing got cycle %0d required %0d", commit_cyc_q[0], k + 3);
      end
      checks++;
      if (rob_iss_empty !== 1'b1) begin
         errors++; $display("FAIL store_empty got %b required 1", rob_iss_empty);
      end
   endtask

   task automatic test_reset_midop();
      do_reset();
      for (int i = 0; i < 5; i++) alloc(5'(1 + i), 1'b1);
      checks++;
      if (rob_iss_empty !== 1'b0) begin
         errors++; $display("FAIL midop_fill got empty=%b required 0", rob_iss_empty);
      end
      reset = 1'b1;
      mul_rob_oper = 1'b1; mul_rob_tag = 3'd0; mul_rob_wbvalue = 32'hDEAD;
      idle(1);
      reset = 1'b0;
      mul_rob_oper = 1'b0;
      checks++;
      if (rob_iss_empty !== 1'b1 || rob_iss_full !== 1'b0 || rob_reg_en !== 1'b0 ||
          rob_iss_tag !== 3'd0) begin
         errors++;
         $display("FAIL midop_reset got empty=%b full=%b en=%b tag=%0d required 1/0/0/0",
                  rob_iss_empty, rob_iss_full, rob_reg_en, rob_iss_tag);
      end
      iss_rob_qaddr = 5'd1;
      #1;
      checks++;
      if (rob_iss_qbusy !== 1'b0) begin
         errors++; $display("FAIL midop_qbusy got %b required 0", rob_iss_qbusy);
      end
      alloc(5'd6, 1'b1);
      idle(3);
      checks++;
      if (rob_iss_empty !== 1'b0 || commit_cyc_q.size() != 0) begin
         errors++;
         $display("FAIL midop_discard got empty=%b writes=%0d required 0/0",
                  rob_iss_empty, commit_cyc_q.size());
      end
   endtask

   initial begin
      idle(1);
      test_reset();
      test_out_of_order();
      test_full_wrap();
      test_same_cycle();
      test_qbusy();
      test_store();
      test_reset_midop();
      idle(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
